bist_ctrl: RTL

BIST sequencer that drives the signature-analysis stage of the self-test path. Generates a 3-bit pseudo-random test pattern stream (e0..e2 stimulus for the circuit under test), sequences the signature register through clear/run/flush, then captures the resulting signature and compares it with a golden value to produce pass/fail. Sits directly upstream and alongside the MISR: it feeds the CUT that feeds the MISR and consumes the MISR's `hf` signature.

---
 rtl/bist_pkg.sv | 25 ++
 rtl/bist_tpg.sv | 38 +++
 rtl/bist_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST sequencer.
// State encoding, TPG taps/seed and the LFSR step function.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_FLUSH,
    ST_CAPTURE,
    ST_DONE
  } bist_state_e;

  localparam int unsigned TPG_W = 3;
  localparam logic [TPG_W-1:0] TPG_TAPS = 3'b110;
  localparam logic [TPG_W-1:0] TPG_SEED_DEF = 3'b001;

  // Fibonacci step: shift left, feed back q[2]^q[1].
  function automatic logic [TPG_W-1:0] lfsr3_next(
    input logic [TPG_W-1:0] q
  );
    return {q[TPG_W-2:0], ^(q & TPG_TAPS)};
  endfunction

endpackage

// File: rtl/bist_tpg.sv
// 3-bit test pattern generator (period-7 LFSR).
// load wins over adv; an all-zero seed becomes 3'b001.
module bist_tpg
  import bist_pkg::*;
#(
  parameter logic [TPG_W-1:0] SEED = TPG_SEED_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic             adv,
  output logic [TPG_W-1:0] q
);

  localparam logic [TPG_W-1:0] SEED_EFF =
    (SEED == '0) ? TPG_SEED_DEF : SEED;

  logic [TPG_W-1:0] q_q;
  logic [TPG_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load)
      q_d = SEED_EFF;
    else if (adv)
      q_d = lfsr3_next(q_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      q_q <= SEED_EFF;
    else
      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/bist_ctrl.sv
// BIST sequencer: TPG, MISR clear/run/flush, signature compare.
// Define BIST_CONT_EN for continuous mode with sticky-fail pass.
module bist_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned N_PATTERNS = 7,
  parameter int unsigned SIG_W = 8,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = '0,
  parameter logic [TPG_W-1:0] TPG_SEED = TPG_SEED_DEF,
  parameter int unsigned FLUSH_CYC = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  output logic [TPG_W-1:0] tpg,
  output logic             misr_clr,
  output logic             misr_en,
  input  logic [SIG_W-1:0] sig_in,
  output logic [SIG_W-1:0] sig_q,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  // Counter is shared by RUN and FLUSH, so size it for the longer one.
  localparam int unsigned CNT_MAX =
    (N_PATTERNS > FLUSH_CYC) ? N_PATTERNS : FLUSH_CYC;
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(N_PATTERNS - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYC - 1);

  bist_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIG_W-1:0] sig_cap_q;
  logic pass_q;
  logic tpg_load;
  logic tpg_adv;
  logic match;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    tpg_load = 1'b0;
    tpg_adv = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tpg_load = 1'b1;
        if (start)
          state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        tpg_load = 1'b1;
        cnt_d = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        tpg_adv = 1'b1;
        if (cnt_q == RUN_LAST) begin
          cnt_d = '0;
          state_d = ST_FLUSH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          cnt_d = '0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
`ifdef BIST_CONT_EN
        state_d = ST_CLEAR;
`else
        if (start)
          state_d = ST_CLEAR;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end

  assign match = (sig_in == GOLDEN_SIG);

`ifdef BIST_CONT_EN
  // ok_q remembers whether every run since reset compared clean.
  logic ok_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sig_cap_q <= '0;
      pass_q <= 1'b0;
      ok_q <= 1'b1;
    end else if (state_q == ST_CAPTURE) begin
      sig_cap_q <= sig_in;
      pass_q <= ok_q & match;
      ok_q <= ok_q & match;
    end
  end
`else
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sig_cap_q <= '0;
      pass_q <= 1'b0;
    end else if (state_q == ST_CAPTURE) begin
      sig_cap_q <= sig_in;
      pass_q <= match;
    end
  end
`endif

  bist_tpg #(
    .SEED(TPG_SEED)
  ) u_tpg (
    .CLK  (CLK),
    .RST_N(RST_N),
    .load (tpg_load),
    .adv  (tpg_adv),
    .q    (tpg)
  );

  assign misr_clr = (state_q == ST_CLEAR);
  assign misr_en = (state_q == ST_RUN);
  assign busy = (state_q == ST_CLEAR) | (state_q == ST_RUN) |
                (state_q == ST_FLUSH) | (state_q == ST_CAPTURE);
  assign done = (state_q == ST_DONE);
  assign pass = pass_q;
  assign sig_q = sig_cap_q;

endmodule
